filter_frame_sequencer: RTL and testbench

//  Sequences one full frame through a fixed-latency pixel filter (3-stage RGB->gray pipeline, no enable/stall).
//  On start: streams every pixel address of a frame buffer, feeds read data to the filter, writes results to an output buffer.

---
 rtl/pix_pkg.sv | 14 +
 rtl/filter_frame_sequencer_delay_line.sv | 28 ++
 rtl/filter_frame_sequencer.sv | 87 ++++++++
 tb/tb_filter_frame_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pix_pkg.sv
// pix_pkg: shared pixel format and sequencer state encoding
package pix_pkg;
    localparam int PIX_W = 24;
    localparam int CH_W  = 8;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } pix_t;
endpackage

// File: rtl/filter_frame_sequencer_delay_line.sv
// delay_line: fixed-depth shift register with async clear and sync flush; depth 0 is a wire
module delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    if (DEPTH == 0) begin : g_wire
        assign q = d;
    end else begin : g_reg
        logic [W-1:0] s [DEPTH];
        // shift one stage per cycle; flush empties every stage at once
        always_ff @(posedge clk or negedge rst)
            if (!rst)
                for (int i = 0; i < DEPTH; i++) s[i] <= '0;
            else if (flush)
                for (int i = 0; i < DEPTH; i++) s[i] <= '0;
            else begin
                s[0] <= d;
                for (int i = 1; i < DEPTH; i++) s[i] <= s[i-1];
            end
        assign q = s[DEPTH-1];
    end
endmodule

// File: rtl/filter_frame_sequencer.sv
// filter_frame_sequencer: streams a frame through a fixed-latency filter into an output buffer
module filter_frame_sequencer
    import pix_pkg::*;
#(
    parameter int WIDTH   = 320,
    parameter int HEIGHT  = 240,
    parameter int ADDR_W  = 17,
    parameter int RD_LAT  = 1,
    parameter int FLT_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [CH_W-1:0]   flt_r_o,
    output logic [CH_W-1:0]   flt_g_o,
    output logic [CH_W-1:0]   flt_b_o,
    input  logic [CH_W-1:0]   flt_r_i,
    input  logic [CH_W-1:0]   flt_g_i,
    input  logic [CH_W-1:0]   flt_b_i,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data
);
    localparam int N = WIDTH * HEIGHT;
    localparam int L = RD_LAT + FLT_LAT;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    logic [1:0]       state;
    logic             mode_q;
    logic             flush;
    logic [PIX_W-1:0] byp_data;
    pix_t             px;

    assign px      = rd_data;
    assign flt_r_o = px.r;
    assign flt_g_o = px.g;
    assign flt_b_o = px.b;
    assign rd_en   = state == S_RUN;
    assign busy    = state == S_RUN || state == S_DRAIN;
    assign done    = state == S_DONE;
    assign flush   = abort && busy;
    assign wr_data = wr_en ? (mode_q ? byp_data : {flt_r_i, flt_g_i, flt_b_i}) : '0;

    // frame FSM and read address counter; abort while busy returns straight to idle
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state   <= S_IDLE;
            rd_addr <= '0;
            mode_q  <= 1'b0;
        end else if (flush)
            state <= S_IDLE;
        else
            case (state)
                S_IDLE:
                    if (start && !abort) begin
                        state   <= S_RUN;
                        rd_addr <= '0;
                        mode_q  <= mode;
                    end
                S_RUN:
                    if (rd_addr == LAST) state <= S_DRAIN;
                    else rd_addr <= rd_addr + 1'b1;
                S_DRAIN:
                    if (wr_en && wr_addr == LAST) state <= S_DONE;
                default:
                    state <= S_IDLE;
            endcase

    delay_line #(.W(1), .DEPTH(L)) u_valid (
        .clk(clk), .rst(rst), .flush(flush), .d(rd_en), .q(wr_en)
    );

    delay_line #(.W(ADDR_W), .DEPTH(L)) u_addr (
        .clk(clk), .rst(rst), .flush(flush), .d(rd_addr), .q(wr_addr)
    );

    delay_line #(.W(PIX_W), .DEPTH(FLT_LAT)) u_byp (
        .clk(clk), .rst(rst), .flush(flush), .d(rd_data), .q(byp_data)
    );
endmodule

// File: tb/tb_filter_frame_sequencer.sv
// tb_filter_frame_sequencer: directed checks of frame timing, bypass, abort, restart and reset
module tb_filter_frame_sequencer;
    localparam int CYC = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        mode = 1'b0;
    logic        busy, done, rd_en, wr_en;
    logic [2:0]  rd_addr, wr_addr;
    logic [23:0] rd_data = '0;
    logic [23:0] wr_data;
    logic [7:0]  flt_r_o, flt_g_o, flt_b_o, flt_r_i, flt_g_i, flt_b_i;
    logic [23:0] f1, f2, f3;
    logic [23:0] mem [8];

    logic        e_wr [CYC];
    logic [2:0]  a_wr [CYC];
    logic [23:0] d_wr [CYC];
    logic        dn [CYC];
    logic        bz [CYC];
    logic        re [CYC];
    logic [2:0]  ra [CYC];

    int n_vec = 0;
    int n_err = 0;

    filter_frame_sequencer #(
        .WIDTH(4), .HEIGHT(2), .ADDR_W(3), .RD_LAT(1), .FLT_LAT(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .flt_r_o(flt_r_o), .flt_g_o(flt_g_o), .flt_b_o(flt_b_o),
        .flt_r_i(flt_r_i), .flt_g_i(flt_g_i), .flt_b_i(flt_b_i),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gray(input logic [23:0] p);
        int y;
        y = (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) >> 8;
        return 8'(y);
    endfunction

    // frame-buffer model: one cycle read latency
    always @(posedge clk)
        if (rd_en) rd_data <= mem[rd_addr];

    // filter model: three register stages, gray replicated on all channels
    always @(posedge clk) begin
        f1 <= {3{gray({flt_r_o, flt_g_o, flt_b_o})}};
        f2 <= f1;
        f3 <= f2;
    end
    assign {flt_r_i, flt_g_i, flt_b_i} = f3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic frame(input logic m, input int s2, input logic m2, input int ab, input int ab2, input int rc);
        for (int c = 0; c < CYC; c++) begin
            start = (c == 0) || (c == s2);
            mode  = (c == s2) ? m2 : m;
            abort = (c == ab) || (c == ab2);
            rst   = (c != rc);
            @(negedge clk);
            e_wr[c] = wr_en;
            a_wr[c] = wr_addr;
            d_wr[c] = wr_data;
            dn[c]   = done;
            bz[c]   = busy;
            re[c]   = rd_en;
            ra[c]   = rd_addr;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b1;
    endtask

    task automatic check_frame(input int lo, input int hi, input int base, input logic m);
        for (int c = lo; c <= hi; c++) begin
            int k;
            k = c - base;
            check($sformatf("rd_en@%0d", c), 32'(re[c]), 32'(k >= 1 && k <= 8));
            if (k >= 1 && k <= 8) check($sformatf("rd_addr@%0d", c), 32'(ra[c]), 32'(k - 1));
            check($sformatf("busy@%0d", c), 32'(bz[c]), 32'(k >= 1 && k <= 12));
            check($sformatf("done@%0d", c), 32'(dn[c]), 32'(k == 13));
            check($sformatf("wr_en@%0d", c), 32'(e_wr[c]), 32'(k >= 5 && k <= 12));
            if (k >= 5 && k <= 12) begin
                check($sformatf("wr_addr@%0d", c), 32'(a_wr[c]), 32'(k - 5));
                check($sformatf("wr_data@%0d", c), 32'(d_wr[c]),
                      32'(m ? mem[k-5] : {3{gray(mem[k-5])}}));
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) mem[k] = {8'(10 * k), 8'(20 + 5 * k), 8'(200 - k)};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // filter frame
        frame(1'b0, -1, 1'b0, -1, -1, -1);
        check_frame(0, CYC - 1, 0, 1'b0);

        // abort at 4, then a start coinciding with abort while idle
        frame(1'b0, 6, 1'b0, 4, 6, -1);
        for (int c = 0; c < CYC; c++) begin
            check($sformatf("ab_rd_en@%0d", c), 32'(re[c]), 32'(c >= 1 && c <= 4));
            check($sformatf("ab_busy@%0d", c), 32'(bz[c]), 32'(c >= 1 && c <= 4));
            check($sformatf("ab_wr_en@%0d", c), 32'(e_wr[c]), 0);
            check($sformatf("ab_done@%0d", c), 32'(dn[c]), 0);
        end

        // second start while busy, with the opposite mode
        frame(1'b0, 3, 1'b1, -1, -1, -1);
        check_frame(0, CYC - 1, 0, 1'b0);

        // reset asserted in cycle 6
        frame(1'b0, -1, 1'b0, -1, -1, 6);
        check("rs_wr_en@5", 32'(e_wr[5]), 1);
        check("rs_wr_en@6", 32'(e_wr[6]), 0);
        check("rs_busy@6", 32'(bz[6]), 0);
        check("rs_rd_en@6", 32'(re[6]), 0);
        check("rs_rd_addr@6", 32'(ra[6]), 0);
        check("rs_wr_addr@6", 32'(a_wr[6]), 0);
        check("rs_wr_data@6", 32'(d_wr[6]), 0);
        for (int c = 7; c < CYC; c++) begin
            check($sformatf("rs_wr_en@%0d", c), 32'(e_wr[c]), 0);
            check($sformatf("rs_busy@%0d", c), 32'(bz[c]), 0);
            check($sformatf("rs_done@%0d", c), 32'(dn[c]), 0);
        end

        // back-to-back frames: restart in the cycle after done
        frame(1'b0, 14, 1'b0, -1, -1, -1);
        check_frame(0, 13, 0, 1'b0);
        check_frame(14, CYC - 1, 14, 1'b0);

        // bypass copy
        mem[3] = 24'h123456;
        frame(1'b1, -1, 1'b1, -1, -1, -1);
        check_frame(0, CYC - 1, 0, 1'b1);
        check("byp_addr@8", 32'(a_wr[8]), 3);
        check("byp_data@8", 32'(d_wr[8]), 32'h123456);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
